// File: rtl/led_mmio_ctrl_if.sv
// Shared store/readback bus between the write demux and the LED peripheral.
interface led_mmio_ctrl_if;
   logic        ledWriteEnable;
   logic [31:0] address;
   logic [31:0] writeData;
   logic [31:0] readData;

   modport master (output ledWriteEnable, address, writeData, input readData);
   modport slave  (input ledWriteEnable, address, writeData, output readData);
endinterface

// File: rtl/led_mmio_ctrl.sv
// Memory-mapped LED peripheral: VALUE/CTRL/PERIOD/STATUS registers, blink engine
// and a registered LED output stage.
module led_mmio_ctrl #(
   parameter int unsigned NUM_LEDS       = 16,
   parameter int unsigned CNT_WIDTH      = 32,
   parameter int unsigned DEFAULT_PERIOD = 50_000_000
) (
   input  logic                clk,
   input  logic                rst,
   led_mmio_ctrl_if.slave      bus,
   output logic [NUM_LEDS-1:0] leds
);

   typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, OFF = 2'd2} state_e;

   state_e               state_q, state_d;
   logic [NUM_LEDS-1:0]  value_q, value_d, leds_q, leds_d;
   logic                 blink_en_q, blink_en_d, invert_q, invert_d;
   logic                 phase_q, phase_d;
   logic [CNT_WIDTH-1:0] period_q, period_d, cnt_q, cnt_d, period_m1;
   logic                 wr_period;
   logic                 unused_addr;

   assign unused_addr = ^{bus.address[31:4], bus.address[1:0]};
   assign wr_period   = bus.ledWriteEnable && (bus.address[3:2] == 2'd2);
   // PERIOD of 0 behaves as 1, so the terminal count is 0 in both cases
   assign period_m1   = (period_q == '0) ? '0 : period_q - CNT_WIDTH'(1);
   assign leds        = leds_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         value_q    <= '0;
         blink_en_q <= 1'b0;
         invert_q   <= 1'b0;
         period_q   <= CNT_WIDTH'(DEFAULT_PERIOD);
         cnt_q      <= '0;
         phase_q    <= 1'b0;
         leds_q     <= '0;
      end else begin
         state_q    <= state_d;
         value_q    <= value_d;
         blink_en_q <= blink_en_d;
         invert_q   <= invert_d;
         period_q   <= period_d;
         cnt_q      <= cnt_d;
         phase_q    <= phase_d;
         leds_q     <= leds_d;
      end
   end

   always_comb begin
      value_d    = value_q;
      blink_en_d = blink_en_q;
      invert_d   = invert_q;
      period_d   = period_q;
      state_d    = state_q;
      cnt_d      = cnt_q;
      phase_d    = phase_q;

      if (bus.ledWriteEnable) begin
         case (bus.address[3:2])
            2'd0: value_d = bus.writeData[NUM_LEDS-1:0];
            2'd1: begin
               blink_en_d = bus.writeData[0];
               invert_d   = bus.writeData[1];
            end
            2'd2: period_d = bus.writeData[CNT_WIDTH-1:0];
            default: ;
         endcase
      end

      case (state_q)
         IDLE: begin
            cnt_d   = '0;
            phase_d = 1'b0;
            if (blink_en_q) state_d = ON;
         end
         ON, OFF: begin
            // A PERIOD write restarts the current half-phase instead of toggling
            if (wr_period) begin
               cnt_d = '0;
            end else if (cnt_q == period_m1) begin
               cnt_d   = '0;
               state_d = (state_q == ON) ? OFF : ON;
               phase_d = ~phase_q;
            end else begin
               cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            phase_d = 1'b0;
         end
      endcase

      if (!blink_en_q) begin
         state_d = IDLE;
         cnt_d   = '0;
         phase_d = 1'b0;
      end
   end

   always_comb begin
      leds_d = ((state_q == OFF) ? '0 : value_q) ^ {NUM_LEDS{invert_q}};
      case (bus.address[3:2])
         2'd0:    bus.readData = 32'(value_q);
         2'd1:    bus.readData = {30'd0, invert_q, blink_en_q};
         2'd2:    bus.readData = 32'(period_q);
         default: bus.readData = {29'd0, state_q, phase_q};
      endcase
   end

endmodule
